mem_access_unit: RTL and testbench

Load/store sequencer between the EX/MEM pipeline register and the byte-addressed, big-endian data memory. Converts LW/LH/LHU/LB/LBU/SW/SH/SB requests into word-wide memory accesses. Sub-word stores use a two-cycle read-modify-write with a pipeline stall. Registers extended load data for the MEM/WB stage and flags misaligned or out-of-range accesses.

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between EX/MEM and a big-endian, word-wide data memory.
// Sub-word stores run a two-cycle read-modify-write and stall the pipeline once.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    IDLE,
    RMW_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        access_err_q, access_err_d;

  logic        is_byte, is_half, is_word;
  logic        aligned, in_range, legal;
  logic [1:0]  lane;
  logic [31:0] waddr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic [31:0] merged;

  assign lane  = req_addr[1:0];
  assign waddr = {req_addr[31:2], 2'b00};

  // Size decode and legality (alignment, size encoding, address range)
  always_comb begin
    is_byte  = (req_size == 2'b00);
    is_half  = (req_size == 2'b01);
    is_word  = (req_size == 2'b10);
    in_range = (req_addr < 32'(MEM_BYTES));
    unique case (1'b1)
      is_byte: aligned = 1'b1;
      is_half: aligned = ~req_addr[0];
      is_word: aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal = req_valid & in_range & aligned;
  end

  // Lane extraction and sign/zero extension of the read word
  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0: byte_sel = mem_rdata[31:24];
      2'd1: byte_sel = mem_rdata[23:16];
      2'd2: byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lane[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    unique case (1'b1)
      is_byte:
        ext_data = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
      is_half:
        ext_data = {{16{~req_unsigned & half_sel[15]}}, half_sel};
      default:
        ext_data = mem_rdata;
    endcase
  end

  // Merge store data into the read word for sub-word stores
  always_comb begin
    merged = mem_rdata;
    if (is_half) begin
      if (lane[1]) merged[15:0]  = req_wdata[15:0];
      else         merged[31:16] = req_wdata[15:0];
    end else begin
      case (lane)
        2'd0: merged[31:24] = req_wdata[7:0];
        2'd1: merged[23:16] = req_wdata[7:0];
        2'd2: merged[15:8]  = req_wdata[7:0];
        default: merged[7:0] = req_wdata[7:0];
      endcase
    end
  end

  // Next-state and memory-port control
  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    merged_d     = merged_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    access_err_d = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = waddr;
    mem_wdata    = 32'h0;
    stall        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!legal) begin
            access_err_d = 1'b1;
          end else if (!req_write) begin
            mem_read     = 1'b1;
            load_data_d  = ext_data;
            load_valid_d = 1'b1;
          end else if (is_word) begin
            mem_write = 1'b1;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
            waddr_d  = waddr;
            merged_d = merged;
            state_d  = RMW_WRITE;
          end
        end
      end
      RMW_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = merged_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any pending merge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      waddr_q      <= 32'h0;
      merged_q     <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      merged_q     <= merged_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      access_err_q <= access_err_d;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory.
// Expected per-cycle results are queued at drive time and popped after the edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, load_valid, access_err;
  logic        mem_read, mem_write;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .access_err(access_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a,
                     input logic [31:0] wd);
    req_valid = v; req_write = w; req_size = sz;
    req_unsigned = u; req_addr = a; req_wdata = wd;
    #1;
  endtask

  task automatic expect_c(input logic v, input logic [31:0] d,
                          input logic e);
    exp_t x;
    x.v = v; x.d = d; x.e = e;
    sb.push_back(x);
  endtask

  task automatic step(input string tag);
    exp_t x;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_lv"}, load_valid, x.v);
      chk({tag, "_err"}, access_err, x.e);
      if (x.v) chk({tag, "_data"}, load_data, x.d);
    end
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] exp);
    drv(1'b1, 1'b0, sz, u, a, 32'h0);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_rd"}, mem_read, 1'b1);
    chk({tag, "_wr"}, mem_write, 1'b0);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    expect_c(1'b1, exp, 1'b0);
    step(tag);
  endtask

  task automatic bad(input string tag, input logic w, input logic [1:0] sz,
                     input logic [31:0] a);
    drv(1'b1, w, sz, 1'b0, a, 32'hDEADBEEF);
    chk({tag, "_rd"}, mem_read, 1'b0);
    chk({tag, "_wr"}, mem_write, 1'b0);
    chk({tag, "_stall"}, stall, 1'b0);
    expect_c(1'b0, 32'h0, 1'b1);
    step(tag);
  endtask

  task automatic sw(input string tag, input logic [31:0] a,
                    input logic [31:0] wd);
    drv(1'b1, 1'b1, 2'b10, 1'b0, a, wd);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_rd"}, mem_read, 1'b0);
    chk({tag, "_wr"}, mem_write, 1'b1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_wdata"}, mem_wdata, wd);
    expect_c(1'b0, 32'h0, 1'b0);
    step(tag);
  endtask

  task automatic subst(input string tag, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] merged);
    drv(1'b1, 1'b1, sz, 1'b0, a, wd);
    chk({tag, "_stall1"}, stall, 1'b1);
    chk({tag, "_rd1"}, mem_read, 1'b1);
    chk({tag, "_wr1"}, mem_write, 1'b0);
    chk({tag, "_addr1"}, mem_addr, {a[31:2], 2'b00});
    expect_c(1'b0, 32'h0, 1'b0);
    step({tag, "_c1"});
    chk({tag, "_stall2"}, stall, 1'b0);
    chk({tag, "_rd2"}, mem_read, 1'b0);
    chk({tag, "_wr2"}, mem_write, 1'b1);
    chk({tag, "_addr2"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_wdata2"}, mem_wdata, merged);
    expect_c(1'b0, 32'h0, 1'b0);
    step({tag, "_c2"});
    chk({tag, "_mem"}, mem[a[9:2]], merged);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    bd_idx = idx; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bd_we = 1'b0; bd_idx = 8'h0; bd_data = 32'h0;
    drv(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    preload(8'h30 >> 2, 32'h00000004);
    preload(8'h1C >> 2, 32'hAC090038);
    preload(8'h34 >> 2, 32'h00000002);
    preload(8'h38 >> 2, 32'h00000000);
    preload(8'hFF, 32'h12345678);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_load_valid", load_valid, 1'b0);
    chk("rst_access_err", access_err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_rd", mem_read, 1'b0);
    chk("rst_mem_wr", mem_write, 1'b0);
    rst = 1'b0;

    load("lw30", 2'b10, 1'b0, 32'h30, 32'h00000004);
    load("lb1c", 2'b00, 1'b0, 32'h1C, 32'hFFFFFFAC);
    load("lbu1c", 2'b00, 1'b1, 32'h1C, 32'h000000AC);
    load("lh1e", 2'b01, 1'b0, 32'h1E, 32'h00000038);
    load("lh1c", 2'b01, 1'b0, 32'h1C, 32'hFFFFAC09);
    load("lhu1c", 2'b01, 1'b1, 32'h1C, 32'h0000AC09);
    load("lb1d", 2'b00, 1'b0, 32'h1D, 32'h00000009);
    load("lb1f", 2'b00, 1'b0, 32'h1F, 32'h00000038);
    load("lw3fc", 2'b10, 1'b0, 32'h3FC, 32'h12345678);

    subst("sb35", 2'b00, 32'h35, 32'h0000005A, 32'h005A0002);
    load("lw34_sb", 2'b10, 1'b0, 32'h34, 32'h005A0002);

    bad("sw31", 1'b1, 2'b10, 32'h31);
    bad("lh33", 1'b0, 2'b01, 32'h33);
    bad("sz11", 1'b0, 2'b11, 32'h30);
    bad("lw400", 1'b0, 2'b10, 32'h400);
    bad("sb400", 1'b1, 2'b00, 32'h400);
    chk("illegal_mem30", mem[8'h30 >> 2], 32'h00000004);

    // restore word 0x34 through the backdoor during an idle cycle
    drv(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bd_idx = 8'h34 >> 2; bd_data = 32'h00000002; bd_we = 1'b1;
    expect_c(1'b0, 32'h0, 1'b0);
    step("restore");
    bd_we = 1'b0;

    drv(1'b1, 1'b1, 2'b01, 1'b0, 32'h36, 32'h0000BEEF);
    chk("sh_rst_stall1", stall, 1'b1);
    expect_c(1'b0, 32'h0, 1'b0);
    step("sh_rst_c1");
    chk("sh_rst_in_rmw", mem_write, 1'b1);
    rst = 1'b1;
    drv(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("sh_rst_wr", mem_write, 1'b0);
    chk("sh_rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    chk("sh_rst_lv", load_valid, 1'b0);
    chk("sh_rst_err", access_err, 1'b0);
    rst = 1'b0;
    chk("sh_rst_mem34", mem[8'h34 >> 2], 32'h00000002);
    load("lw34_rst", 2'b10, 1'b0, 32'h34, 32'h00000002);

    load("alt_lw0", 2'b10, 1'b0, 32'h38, 32'h00000000);
    sw("alt_sw0", 32'h38, 32'h11223344);
    load("alt_lw1", 2'b10, 1'b0, 32'h38, 32'h11223344);
    sw("alt_sw1", 32'h38, 32'hCAFEF00D);
    load("alt_lw2", 2'b10, 1'b0, 32'h38, 32'hCAFEF00D);

    subst("sh38", 2'b01, 32'h38, 32'h0000BEEF, 32'hBEEFF00D);
    load("lhu38", 2'b01, 1'b1, 32'h38, 32'h0000BEEF);
    load("lh3a", 2'b01, 1'b0, 32'h3A, 32'hFFFFF00D);
    subst("sb3b", 2'b00, 32'h3B, 32'h000000A5, 32'hBEEFF0A5);
    load("lbu3b", 2'b00, 1'b1, 32'h3B, 32'h000000A5);

    drv(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    expect_c(1'b0, 32'h0, 1'b0);
    step("idle_end");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
